// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 codes, request record.
package lsu_pkg;
  localparam int LSU_XLEN   = 32;
  localparam int LSU_LANES  = 4;
  localparam int LSU_BYTE_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, RMW_WR, ST_WR, RESP} lsu_state_t;

  typedef struct packed {
    logic                we;
    logic [2:0]          funct3;
    logic [LSU_XLEN-1:0] addr;
    logic [LSU_XLEN-1:0] wdata;
  } lsu_req_t;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3 > F3_W;
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  // Halfwords snap to their natural lane pair, words to lane 0.
  function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return off;
      2'b01:   return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction
endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: load extraction/extension and sub-word store merge into a word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int NUM_LANES = LSU_LANES,
  parameter int VEC_W     = LSU_BYTE_W
) (
  input  logic [2:0]                          funct3,
  input  logic [1:0]                          off,
  input  logic [NUM_LANES-1:0][VEC_W-1:0]     mem_word,
  input  logic [NUM_LANES-1:0][VEC_W-1:0]     st_data,
  output logic [NUM_LANES*VEC_W-1:0]          ld_data,
  output logic [NUM_LANES-1:0][VEC_W-1:0]     st_word
);
  localparam int W = NUM_LANES * VEC_W;

  logic [VEC_W-1:0]   byte_sel;
  logic [2*VEC_W-1:0] half_sel;

  assign byte_sel = mem_word[off];
  assign half_sel = {mem_word[{off[1], 1'b1}], mem_word[{off[1], 1'b0}]};

  always_comb begin
    ld_data = mem_word;
    case (funct3)
      F3_B:  ld_data = {{(W-VEC_W){byte_sel[VEC_W-1]}}, byte_sel};
      F3_BU: ld_data = {{(W-VEC_W){1'b0}}, byte_sel};
      F3_H:  ld_data = {{(W-2*VEC_W){half_sel[2*VEC_W-1]}}, half_sel};
      F3_HU: ld_data = {{(W-2*VEC_W){1'b0}}, half_sel};
      default: ;
    endcase
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [1:0] K = 2'(k);
    logic [VEC_W-1:0] src;
    logic             hit;
    always_comb begin
      src = st_data[k];
      hit = 1'b1;
      if (funct3 == F3_B) begin
        src = st_data[0];
        hit = (off == K);
      end else if (funct3 == F3_H) begin
        src = st_data[k % 2];
        hit = (off[1] == K[1]);
      end
    end
    assign st_word[k] = hit ? src : mem_word[k];
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: RV32I loads/stores onto a word SRAM; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of truncating.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_LSB = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  output logic            mem_re,
  input  logic [XLEN-1:0] mem_rdata
);
  lsu_state_t      state_q, state_d;
  lsu_req_t        req_q;
  logic [XLEN-1:0] buf_q, rdata_q, ld_data, st_word, word_addr, align_in;
  logic            err_q, bad_in;
  logic [1:0]      off;

  // Classified at accept so an error can answer in the very next cycle.
`ifdef LSU_MISALIGN_TRAP_EN
  assign bad_in = f3_illegal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
  assign bad_in = f3_illegal(req_we, req_funct3);
`endif

  assign word_addr = {req_q.addr[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
  assign off       = eff_off(req_q.funct3, req_q.addr[1:0]);
  assign align_in  = req_q.we ? buf_q : mem_rdata;

  lsu_align u_align (
    .funct3   (req_q.funct3),
    .off      (off),
    .mem_word (align_in),
    .st_data  (req_q.wdata),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad_in)                   state_d = RESP;
          else if (!req_we)             state_d = LOAD;
          else if (req_funct3 == F3_W)  state_d = ST_WR;
          else                          state_d = RMW_RD;
        end
      end
      LOAD: begin
        mem_re   = 1'b1;
        mem_addr = word_addr;
        state_d  = RESP;
      end
      RMW_RD: begin
        mem_re   = 1'b1;
        mem_addr = word_addr;
        state_d  = RMW_WR;
      end
      RMW_WR: begin
        mem_we    = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = st_word;
        state_d   = RESP;
      end
      ST_WR: begin
        mem_we    = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = req_q.wdata;
        state_d   = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      req_q   <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_valid && req_ready)
        req_q <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
      // Response fields only change on entry to RESP, so they hold between responses.
      case (state_q)
        IDLE: if (req_valid && bad_in) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
        LOAD: begin
          rdata_q <= ld_data;
          err_q   <= 1'b0;
        end
        RMW_RD: buf_q <= mem_rdata;
        RMW_WR, ST_WR: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed loads/stores against a small SRAM model.
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  exp_t resp_q[$];
  wr_t  wr_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   mem_act = 0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  lsu_mem_ctrl dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (pl_en)       mem[pl_idx] <= pl_data;
    else if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT responds.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && resp_valid) begin
      if (resp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none");
      end else begin
        e = resp_q.pop_front();
        chk({e.name, "_rdata"}, resp_rdata, e.rdata);
        chk({e.name, "_err"}, 32'(resp_err), 32'(e.err));
        chk({e.name, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  // Write monitor: every SRAM write must match the next expected address/word.
  always @(negedge clk) begin
    wr_t w;
    if (mem_re || mem_we) begin
      mem_act++;
      chk("re_we_exclusive", 32'(mem_re & mem_we), 32'd0);
    end
    if (rstn && mem_we) begin
      if (wr_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: got addr 0x%08h expected no write", mem_addr);
      end else begin
        w = wr_q.pop_front();
        chk("wr_addr", mem_addr, w.addr);
        chk("wr_data", mem_wdata, w.data);
      end
    end
  end

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output int acc, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    ok = req_ready;
    acc = 0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      return;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic issue(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input logic er, input int lat);
    exp_t e;
    int   acc, n;
    bit   ok;
    drive(we, f3, a, wd, acc, ok);
    if (!ok) return;
    e.rdata = rd; e.err = er; e.lat = lat; e.acc = acc; e.name = nm;
    resp_q.push_back(e);
    n = 0;
    while (resp_q.size() != 0 && n < 20) begin @(negedge clk); #1; n++; end
    if (resp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL %s_resp_timeout: got no resp_valid expected one", nm);
      resp_q.delete();
    end
  endtask

  initial begin
    int m0, acc, n;
    bit ok;
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;

    @(negedge clk); pl_en = 1'b1; pl_idx = 8'd4;  pl_data = 32'h8899AABB;
    @(negedge clk);               pl_idx = 8'd12; pl_data = 32'h11223344;
    @(negedge clk); pl_en = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_en", {30'd0, mem_we, mem_re}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rstn = 1'b1;

    issue("lb_13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2);
    issue("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000088, 1'b0, 2);
    issue("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h00008899, 1'b0, 2);
    issue("lh_10",  1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 2);
    issue("lb_10",  1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 2);
    issue("lbu_11", 1'b0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2);

    wr_q.push_back('{32'h10, 32'h88995ABB});
    m0 = mem_act;
    issue("sb_11", 1'b1, 3'b000, 32'h11, 32'hFFFFFF5A, 32'h0, 1'b0, 3);
    chk("sb_mem_cycles", 32'(mem_act - m0), 32'd2);
    issue("lw_10a", 1'b0, 3'b010, 32'h10, 32'h0, 32'h88995ABB, 1'b0, 2);

    wr_q.push_back('{32'h10, 32'h12345ABB});
    issue("sh_12", 1'b1, 3'b001, 32'h12, 32'hABCD1234, 32'h0, 1'b0, 3);
    issue("lw_10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h12345ABB, 1'b0, 2);

    wr_q.push_back('{32'h20, 32'hDEADBEEF});
    m0 = mem_act;
    issue("sw_20", 1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    chk("sw_mem_cycles", 32'(mem_act - m0), 32'd1);

    m0 = mem_act;
    if (TRAP) issue("lw_22", 1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1, 1);
    else      issue("lw_22", 1'b0, 3'b010, 32'h22, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    chk("lw_22_mem_cycles", 32'(mem_act - m0), TRAP ? 32'd0 : 32'd1);

    if (TRAP) issue("lh_21", 1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1, 1);
    else      issue("lh_21", 1'b0, 3'b001, 32'h21, 32'h0, 32'hFFFFBEEF, 1'b0, 2);

    m0 = mem_act;
    issue("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    issue("st_f3_100", 1'b1, 3'b100, 32'h10, 32'h55, 32'h0, 1'b1, 1);
    chk("illegal_mem_cycles", 32'(mem_act - m0), 32'd0);
    issue("lw_10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'h12345ABB, 1'b0, 2);

    // Reset during RMW_WR: the write must not land.
    wr_q.push_back('{32'h30, 32'h112233FF});
    drive(1'b1, 3'b000, 32'h30, 32'h000000FF, acc, ok);
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_we && n < 10);
    chk("rmw_wr_reached", 32'(mem_we), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("midrst_word_kept", mem[12], 32'h11223344);
    @(negedge clk); rstn = 1'b1;
    issue("lw_30", 1'b0, 3'b010, 32'h30, 32'h0, 32'h11223344, 1'b0, 2);

    repeat (3) @(negedge clk);
    chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
